// File: rtl/fetch_unit_pkg.sv
// Shared fetch/decode definitions: FSM encoding, default NOP/HALT words,
// instruction stride and address-wrap helper.
package fetch_unit_pkg;

  localparam int unsigned INSTR_BYTES = 4;
  localparam int unsigned XLEN        = 32;

  localparam logic [XLEN-1:0] FETCH_NOP_WORD  = 32'h0000_0000;
  localparam logic [XLEN-1:0] FETCH_HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

  // Reduce a byte address into the instruction memory window.
  function automatic logic [XLEN-1:0] wrap_addr(input logic [XLEN-1:0] addr,
                                                input int unsigned size);
    return addr % size;
  endfunction

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter: holds, advances by one instruction with wrap, or loads a
// redirect target reduced into the memory window.
module pc_reg
  import fetch_unit_pkg::*;
#(
  parameter int unsigned     MEM_BYTES = 512,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            advance,
  input  logic            redirect,
  input  logic [XLEN-1:0] target,
  output logic [XLEN-1:0] pc
);

  logic [XLEN-1:0] pc_inc_c;
  logic [XLEN-1:0] pc_next_seq_c;

  assign pc_inc_c      = pc + XLEN'(INSTR_BYTES);
  assign pc_next_seq_c = (pc_inc_c >= XLEN'(MEM_BYTES)) ? pc_inc_c - XLEN'(MEM_BYTES)
                                                         : pc_inc_c;

  // Redirect has priority over sequential advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= wrap_addr(target, MEM_BYTES);
    end else if (advance) begin
      pc <= pc_next_seq_c;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: IDLE/RUN/HALTED sequencer, IR register and PC.
// Optional FETCH_ALIGN_CHECK_EN adds a sticky misaligned-redirect flag.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned     MEM_BYTES = 512,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0,
  parameter logic [XLEN-1:0] NOP_WORD  = FETCH_NOP_WORD,
  parameter logic [XLEN-1:0] HALT_WORD = FETCH_HALT_WORD
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            stall,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  output logic [XLEN-1:0] imem_dir,
  input  logic [XLEN-1:0] imem_do,
  output logic [XLEN-1:0] ir,
  output logic [XLEN-1:0] pc_if,
  output logic            valid,
  output logic            halted
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic            align_err
`endif
);

  fetch_state_e    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] target_c;
  logic            run_c;
  logic            redirect_c;
  logic            advance_c;
  logic            is_halt_c;

`ifdef FETCH_ALIGN_CHECK_EN
  assign target_c = {br_target[XLEN-1:2], 2'b00};
`else
  assign target_c = br_target;
`endif

  assign run_c      = (state == ST_RUN);
  assign is_halt_c  = (imem_do == HALT_WORD);
  assign redirect_c = run_c & br_taken;
  assign advance_c  = run_c & ~br_taken & ~stall & ~is_halt_c;
  assign imem_dir   = pc;

  pc_reg #(
    .MEM_BYTES (MEM_BYTES),
    .RESET_PC  (RESET_PC)
  ) u_pc_reg (
    .clk      (clk),
    .rst      (rst),
    .advance  (advance_c),
    .redirect (redirect_c),
    .target   (target_c),
    .pc       (pc)
  );

  // Sequencer and IR/PC_IF/VALID registers; branch beats stall and halt.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      ir        <= NOP_WORD;
      pc_if     <= '0;
      valid     <= 1'b0;
      halted    <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      align_err <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) state <= ST_RUN;
        end
        ST_RUN: begin
          if (br_taken) begin
            ir    <= NOP_WORD;
            valid <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            if (br_target[1:0] != 2'b00) align_err <= 1'b1;
`endif
          end else if (!stall) begin
            ir    <= imem_do;
            pc_if <= pc;
            valid <= 1'b1;
            if (is_halt_c) begin
              state  <= ST_HALTED;
              halted <= 1'b1;
            end
          end
        end
        ST_HALTED: begin
          state <= ST_HALTED;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// traffic compared every cycle against a behavioural model.
module tb_fetch_unit;

  localparam int unsigned MEMB  = 512;
  localparam logic [31:0] HALTW = 32'hFFFF_FFFF;
  localparam logic [31:0] NOPW  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, start, stall, br_taken;
  logic [31:0] br_target, imem_dir, imem_do, ir, pc_if;
  logic        valid, halted;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        align_err;
`endif

  logic [31:0] mem [MEMB/4];
  assign imem_do = mem[imem_dir[8:2]];

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stall     (stall),
    .br_taken  (br_taken),
    .br_target (br_target),
    .imem_dir  (imem_dir),
    .imem_do   (imem_do),
    .ir        (ir),
    .pc_if     (pc_if),
    .valid     (valid),
    .halted    (halted)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .align_err (align_err)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: mode 0 = idle, 1 = fetching, 2 = stopped.
  int          m_mode;
  logic [31:0] m_pc, m_ir, m_pcif;
  bit          m_valid, m_halted, m_align;

  task automatic model_step(input bit r, input bit s, input bit st, input bit b,
                            input logic [31:0] t);
    logic [31:0] w;
    if (r) begin
      m_mode = 0; m_pc = 0; m_ir = NOPW; m_pcif = 0;
      m_valid = 0; m_halted = 0; m_align = 0;
    end else if (m_mode == 0) begin
      if (s) m_mode = 1;
    end else if (m_mode == 1) begin
      if (b) begin
`ifdef FETCH_ALIGN_CHECK_EN
        if (t % 4 != 0) m_align = 1;
        m_pc = (t - t % 4) % MEMB;
`else
        m_pc = t % MEMB;
`endif
        m_ir = NOPW;
        m_valid = 0;
      end else if (!st) begin
        w = mem[m_pc / 4];
        m_ir = w; m_pcif = m_pc; m_valid = 1;
        if (w == HALTW) begin
          m_mode = 2; m_halted = 1;
        end else begin
          m_pc = (m_pc + 4) % MEMB;
        end
      end
    end
  endtask

  task automatic cycle(input bit r, input bit s, input bit st, input bit b,
                       input logic [31:0] t);
    rst = r; start = s; stall = st; br_taken = b; br_target = t;
    model_step(r, s, st, b, t);
    @(posedge clk);
    #1;
    check("ir", ir, m_ir);
    check("pc_if", pc_if, m_pcif);
    check("valid", 32'(valid), 32'(m_valid));
    check("halted", 32'(halted), 32'(m_halted));
    check("imem_dir", imem_dir, m_pc);
`ifdef FETCH_ALIGN_CHECK_EN
    check("align_err", 32'(align_err), 32'(m_align));
`endif
  endtask

  task automatic fill_mem();
    logic [31:0] w;
    for (int i = 0; i < int'(MEMB / 4); i++) begin
      do w = $urandom; while (w == HALTW);
      mem[i] = w;
    end
  endtask

  logic [31:0] snap_ir, snap_pcif;

  initial begin
    rst = 1; start = 0; stall = 0; br_taken = 0; br_target = 0;
    fill_mem();
    mem[0] = 32'h1122_3344; mem[1] = 32'h5566_7788;
    mem[2] = 32'h99AA_BBCC; mem[3] = 32'hDDEE_FF00;

    // Reset, including with other inputs asserted.
    cycle(1, 1, 1, 1, 32'h40);
    cycle(1, 0, 0, 0, 0);
    check("rst_ir", ir, NOPW);
    check("rst_valid", 32'(valid), 32'd0);

    // Branch ignored in idle; idle holds.
    cycle(0, 0, 0, 1, 32'h80);
    check("idle_pc", imem_dir, 32'h0);

    // Start, then first two fetches.
    cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    check("f0_ir", ir, 32'h1122_3344);
    check("f0_pcif", pc_if, 32'h0);
    cycle(0, 0, 0, 0, 0);
    check("f1_ir", ir, 32'h5566_7788);
    check("f1_pcif", pc_if, 32'h4);

    // Three stall cycles at PC=8.
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 0);
    check("stall_pcif", pc_if, 32'h4);
    check("stall_ir", ir, 32'h5566_7788);
    cycle(0, 0, 0, 0, 0);
    check("resume_pcif", pc_if, 32'h8);

    // Branch beats stall.
    cycle(0, 0, 1, 1, 32'h40);
    check("br_valid", 32'(valid), 32'd0);
    check("br_ir", ir, NOPW);
    cycle(0, 0, 0, 0, 0);
    check("br_pcif", pc_if, 32'h40);
    check("br_word", ir, mem[16]);

    // Wrap at the top of memory.
    cycle(0, 0, 0, 1, 32'h1F8);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    check("top_pcif", pc_if, 32'h1FC);
    cycle(0, 0, 0, 0, 0);
    check("wrap_pcif", pc_if, 32'h0);

    // Misaligned redirect.
    cycle(0, 0, 0, 1, 32'h42);
    cycle(0, 0, 0, 0, 0);
`ifdef FETCH_ALIGN_CHECK_EN
    check("align_flag", 32'(align_err), 32'd1);
    check("align_pcif", pc_if, 32'h40);
`else
    check("unalign_pcif", pc_if, 32'h42);
`endif

    // Randomized traffic, occasional reset, no halt words in memory.
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(99) == 0), ($urandom_range(9) == 0),
            ($urandom_range(9) < 3), ($urandom_range(9) == 0),
            ($urandom_range(3) == 0) ? $urandom : 32'($urandom_range(MEMB - 1)));
    end

    // Halt word at 0x0C.
    fill_mem();
    mem[3] = HALTW;
    cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0);
    check("halt_ir", ir, HALTW);
    check("halt_flag", 32'(halted), 32'd1);
    check("halt_pcif", pc_if, 32'hC);
    snap_ir = ir; snap_pcif = pc_if;
    for (int i = 0; i < 10; i++)
      cycle(0, (i % 2 == 0), $urandom_range(1), $urandom_range(1), $urandom);
    check("frozen_ir", ir, snap_ir);
    check("frozen_pcif", pc_if, snap_pcif);
    check("frozen_pc", imem_dir, 32'hC);
    cycle(1, 0, 0, 0, 0);
    check("unhalt", 32'(halted), 32'd0);

    // Branch on the edge a halt word is fetched wins.
    cycle(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 32'h20);
    check("br_vs_halt", 32'(halted), 32'd0);
    cycle(0, 0, 0, 0, 0);
    check("br_vs_halt_pcif", pc_if, 32'h20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
